// File: rtl/morse_symbol_timer.sv
// Morse keyer timing: splits a debounced key level into dot/dash symbols and
// character/word gap pulses, timed in prescaled units that restart on every state change.
module morse_symbol_timer #(
    parameter int DIV_COUNT   = 25,
    parameter int DASH_THRESH = 2,
    parameter int CHAR_GAP    = 3,
    parameter int WORD_GAP    = 7,
    parameter int UNIT_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_EN,
    input  logic       key_in,
    output logic       sym_valid,
    output logic       sym_dash,
    output logic       char_end,
    output logic       word_end,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam int              PW        = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV_COUNT - 1);

    state_t              r_state;
    logic [PW-1:0]       r_presc;
    logic [UNIT_W-1:0]   r_units;
    logic                r_sym_valid;
    logic                r_sym_dash;
    logic                r_char_end;
    logic                r_word_end;

    state_t              w_state_nxt;
    logic [PW-1:0]       w_presc_nxt;
    logic [UNIT_W-1:0]   w_units_nxt;
    logic [UNIT_W-1:0]   w_units_sat;
    logic                w_sym_valid_nxt;
    logic                w_sym_dash_nxt;
    logic                w_char_end_nxt;
    logic                w_word_end_nxt;
    logic                w_tick;
    logic                w_reach_char;
    logic                w_reach_word;

    assign w_tick       = (r_presc == PRESC_MAX);
    assign w_units_sat  = (r_units == '1) ? r_units : r_units + 1'b1;
    // A gap boundary is "reached" on the edge whose tick lands the count on it.
    assign w_reach_char = w_tick && (int'(r_units) + 1 == CHAR_GAP);
    assign w_reach_word = w_tick && (int'(r_units) + 1 == WORD_GAP);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        w_state_nxt     = r_state;
        w_presc_nxt     = r_presc;
        w_units_nxt     = r_units;
        w_sym_valid_nxt = 1'b0;
        w_sym_dash_nxt  = r_sym_dash;
        w_char_end_nxt  = 1'b0;
        w_word_end_nxt  = 1'b0;

        if (in_EN) begin
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
            w_units_nxt = w_tick ? w_units_sat : r_units;

            case (r_state)
                ST_IDLE: begin
                    w_presc_nxt = '0;
                    w_units_nxt = '0;
                    if (key_in) w_state_nxt = ST_MARK;
                end
                ST_MARK: begin
                    if (!key_in) begin
                        w_state_nxt     = ST_SPACE;
                        w_sym_valid_nxt = 1'b1;
                        w_sym_dash_nxt  = (int'(r_units) >= DASH_THRESH);
                    end
                end
                ST_SPACE: begin
                    if (key_in) begin
                        w_state_nxt = ST_MARK;
                    end else if (w_reach_word) begin
                        w_state_nxt    = ST_IDLE;
                        w_word_end_nxt = 1'b1;
                    end else if (w_reach_char) begin
                        w_char_end_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            // Units restart on every state change so they align to key edges.
            if (w_state_nxt != r_state) begin
                w_presc_nxt = '0;
                w_units_nxt = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_units     <= '0;
            r_sym_valid <= 1'b0;
            r_sym_dash  <= 1'b0;
            r_char_end  <= 1'b0;
            r_word_end  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_units     <= w_units_nxt;
            r_sym_valid <= w_sym_valid_nxt;
            r_sym_dash  <= w_sym_dash_nxt;
            r_char_end  <= w_char_end_nxt;
            r_word_end  <= w_word_end_nxt;
        end
    end

    assign sym_valid = r_sym_valid;
    assign sym_dash  = r_sym_dash;
    assign char_end  = r_char_end;
    assign word_end  = r_word_end;
    assign state_out = r_state;

endmodule
